sat_arb: RTL

- Shares one scale-and-saturate stage between N_REQ check-node output streams in the CNU.
- Each requester presents a sign-magnitude extrinsic message. The block grants one requester per cycle, round-robin. The granted magnitude is scaled by 1/4 (right shift by 2) and saturated to an (OUT_SIZE+1)-bit two's-complement value.
- The result is registered with requester ID and a saturation flag, and handed downstream over valid/ready.
- Keeps a saturation-event counter for quantisation tuning.

---
 rtl/sat_arb.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sat_arb.sv
// sat_arb: round-robin arbiter in front of a shared scale-and-saturate stage.
// Each cycle one valid requester is granted; its sign-magnitude message is
// divided by 4, clipped to an (OUT_SIZE+1)-bit two's-complement value and
// registered together with the requester index and a clip flag.
//
// Ports:
//   clk, rst_n  : rising-edge clock, synchronous active-low reset
//   req_valid   : per-requester message valid
//   req_ready   : per-requester accept, one-hot or zero
//   req_mag     : packed magnitudes, requester i at [i*(IN_SIZE+1) +: IN_SIZE+1]
//   req_sgn     : per-requester sign, 1 = negative
//   out_valid   : output register holds a result
//   out_ready   : downstream accept
//   out_data    : scaled, saturated two's-complement result
//   out_id      : requester index that produced out_data
//   out_sat     : result was clipped
//   sat_cnt     : saturating count of clipped results loaded into the output
//   cnt_clr     : synchronous clear of sat_cnt (wins over an increment)
module sat_arb #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned IN_SIZE  = 10,
  parameter int unsigned OUT_SIZE = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*(IN_SIZE+1)-1:0] req_mag,
  input  logic [N_REQ-1:0]             req_sgn,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_SIZE:0]            out_data,
  output logic [ID_W-1:0]              out_id,
  output logic                         out_sat,
  output logic [CNT_W-1:0]             sat_cnt,
  input  logic                         cnt_clr
);

  localparam int unsigned MW = IN_SIZE + 1;

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_SIZE:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_sat_q, out_sat_d;
  logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;

  logic              load;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [N_REQ-1:0]  grant_oh;
  logic [MW-1:0]     mag_sel;
  logic              sgn_sel;
  logic [MW-1:0]     t;
  logic              clip;
  logic [OUT_SIZE:0] res;
  logic              xfer;
  int unsigned       best_d;
  int unsigned       d;

  assign load = !out_valid_q || out_ready;

  // Round-robin pick: the valid requester with the smallest forward distance
  // from ptr wins, which equals an ascending wrap-around search from ptr.
  always_comb begin
    best_d    = N_REQ;
    d         = 0;
    grant_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      d = (i + N_REQ - 32'(ptr_q)) % N_REQ;
      if (req_valid[i] && (d < best_d)) begin
        best_d    = d;
        grant_idx = ID_W'(i);
      end
    end
    grant_found = (best_d < N_REQ);
  end

  always_comb begin
    grant_oh = '0;
    mag_sel  = '0;
    sgn_sel  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_found && (grant_idx == ID_W'(i))) begin
        grant_oh[i] = 1'b1;
        mag_sel     = req_mag[i*MW +: MW];
        sgn_sel     = req_sgn[i];
      end
    end
  end

  assign req_ready = (rst_n && load) ? grant_oh : '0;
  assign xfer      = rst_n && load && grant_found;

  // Scale by 1/4, then clip to the signed output range.
  always_comb begin
    t    = mag_sel >> 2;
    clip = |t[IN_SIZE:OUT_SIZE];
    if (clip) begin
      res = sgn_sel ? {1'b1, {OUT_SIZE{1'b0}}} : {1'b0, {OUT_SIZE{1'b1}}};
    end else begin
      res = sgn_sel ? -t[OUT_SIZE:0] : t[OUT_SIZE:0];
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_sat_d   = out_sat_q;
    sat_cnt_d   = sat_cnt_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = res;
      out_id_d    = grant_idx;
      out_sat_d   = clip;
      ptr_d       = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (cnt_clr) begin
      sat_cnt_d = '0;
    end else if (xfer && clip && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_sat_q   <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_sat_q   <= out_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_sat   = out_sat_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
